// File: rtl/instr_mem_sync_if.sv
// Fetch/load bus between the fetch stage (or loader) and the synchronous
// instruction memory.
interface instr_mem_sync_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  // Handshake: fetch_req is the request valid and (!fetch_stall && !busy) is
  // ready; a request is taken only on an edge where both hold, otherwise it is
  // dropped rather than queued. instr_valid marks a fresh result the cycle
  // after acceptance and is held (with instr/addr_err) while fetch_stall=1.
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_err;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              busy;

  modport master (
    output fetch_req, fetch_addr, fetch_stall, load_en, load_addr, load_data,
    input  instr, instr_valid, addr_err, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, fetch_stall, load_en, load_addr, load_data,
    output instr, instr_valid, addr_err, busy
  );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory: registered fetch with stall hold, run-time
// load port, post-reset fill to NOP_WORD and out-of-range detection.
module instr_mem_sync #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 10,
  parameter int                DEPTH          = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD       = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_mem_sync_if.slave  bus,
  output logic             state_dbg
);

  localparam int                CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_READY;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              busy_int, fill_we, fetch_go, load_go;
  logic              fetch_in_range, load_in_range, bypass;
  logic [CNT_W-1:0]  fetch_idx, load_idx;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q, err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  // Full-width compare: addresses at or above DEPTH never alias into the array.
  assign fetch_in_range = {1'b0, bus.fetch_addr} < DEPTH_X;
  assign load_in_range  = {1'b0, bus.load_addr}  < DEPTH_X;
  assign fetch_idx      = bus.fetch_addr[CNT_W-1:0];
  assign load_idx       = bus.load_addr[CNT_W-1:0];
  assign bypass         = load_go && (load_idx == fetch_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_INIT) begin
      if (cnt == LAST_IDX) begin
        state_nxt = ST_READY;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    busy_int = 1'b0;
    fill_we  = 1'b0;
    fetch_go = 1'b0;
    load_go  = 1'b0;
    case (state)
      ST_INIT: begin
        busy_int = 1'b1;
        fill_we  = 1'b1;
      end
      ST_READY: begin
        fetch_go = bus.fetch_req && !bus.fetch_stall;
        load_go  = bus.load_en && load_in_range;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[cnt] <= NOP_WORD;
    end else if (load_go) begin
      mem[load_idx] <= bus.load_data;
    end
  end

  // Write-first: a same-edge load to the fetched address forwards load_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (!bus.fetch_stall) begin
      if (fetch_go) begin
        valid_q <= 1'b1;
        if (fetch_in_range) begin
          err_q   <= 1'b0;
          instr_q <= bypass ? bus.load_data : mem[fetch_idx];
        end else begin
          err_q   <= 1'b1;
          instr_q <= NOP_WORD;
        end
      end else begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.addr_err    = err_q;
  assign bus.busy        = busy_int;
  assign state_dbg       = state;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: two instances (DEPTH 1024 and 768) share one
// stimulus stream and are checked each cycle against an array-based model.
module tb_instr_mem_sync;
  localparam int          DW      = 16;
  localparam int          AW      = 10;
  localparam int          DEPTH_A = 1024;
  localparam int          DEPTH_B = 768;
  localparam logic [15:0] NOP     = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0, fetch_stall = 1'b0, load_en = 1'b0;
  logic [AW-1:0] fetch_addr = '0, load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          state_dbg_a, state_dbg_b;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  instr_mem_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  instr_mem_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  assign bus_a.fetch_req   = fetch_req;
  assign bus_a.fetch_addr  = fetch_addr;
  assign bus_a.fetch_stall = fetch_stall;
  assign bus_a.load_en     = load_en;
  assign bus_a.load_addr   = load_addr;
  assign bus_a.load_data   = load_data;
  assign bus_b.fetch_req   = fetch_req;
  assign bus_b.fetch_addr  = fetch_addr;
  assign bus_b.fetch_stall = fetch_stall;
  assign bus_b.load_en     = load_en;
  assign bus_b.load_addr   = load_addr;
  assign bus_b.load_data   = load_data;

  instr_mem_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_A), .NOP_WORD(NOP),
                   .CLEAR_ON_RESET(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a), .state_dbg(state_dbg_a));

  instr_mem_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_B), .NOP_WORD(NOP),
                   .CLEAR_ON_RESET(1'b1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b), .state_dbg(state_dbg_b));

  // ---------------- reference model ----------------
  int          depth_m [2] = '{DEPTH_A, DEPTH_B};
  logic [15:0] mem_m [2][1024];
  logic [15:0] exp_instr [2];
  logic        exp_valid [2];
  logic        exp_err [2];
  int          fill_left [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      fill_left[k] = depth_m[k];
      exp_instr[k] = NOP;
      exp_valid[k] = 1'b0;
      exp_err[k]   = 1'b0;
      for (int i = 0; i < 1024; i++) mem_m[k][i] = NOP;
    end
  endtask

  // Applies one rising edge using the inputs that were stable before it.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (fill_left[k] > 0) begin
          fill_left[k]--;
          if (!fetch_stall) begin
            exp_valid[k] = 1'b0;
            exp_err[k]   = 1'b0;
          end
        end else begin
          if (!fetch_stall) begin
            if (fetch_req) begin
              exp_valid[k] = 1'b1;
              if (int'(fetch_addr) < depth_m[k]) begin
                exp_err[k]   = 1'b0;
                exp_instr[k] = (load_en && load_addr == fetch_addr) ? load_data
                                                                   : mem_m[k][fetch_addr];
              end else begin
                exp_err[k]   = 1'b1;
                exp_instr[k] = NOP;
              end
            end else begin
              exp_valid[k] = 1'b0;
              exp_err[k]   = 1'b0;
            end
          end
          if (load_en && int'(load_addr) < depth_m[k]) mem_m[k][load_addr] = load_data;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("instr_a", 32'(bus_a.instr), 32'(exp_instr[0]));
    check("valid_a", 32'(bus_a.instr_valid), 32'(exp_valid[0]));
    check("err_a", 32'(bus_a.addr_err), 32'(exp_err[0]));
    check("busy_a", 32'(bus_a.busy), 32'(fill_left[0] > 0));
    check("instr_b", 32'(bus_b.instr), 32'(exp_instr[1]));
    check("valid_b", 32'(bus_b.instr_valid), 32'(exp_valid[1]));
    check("err_b", 32'(bus_b.addr_err), 32'(exp_err[1]));
    check("busy_b", 32'(bus_b.busy), 32'(fill_left[1] > 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic req, input int addr, input logic stall,
                        input logic len, input int laddr, input logic [15:0] ldata);
    fetch_req   = req;
    fetch_addr  = AW'(addr);
    fetch_stall = stall;
    load_en     = len;
    load_addr   = AW'(laddr);
    load_data   = ldata;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  // Fetch and load are hammered during the fill; both must be ignored.
  task automatic wait_fill(input string tag);
    int na = 0;
    int nb = 0;
    int guard = 0;
    while (bus_a.busy && guard < 3000) begin
      if (bus_b.busy) nb++;
      na++;
      set_in(1'b1, $urandom_range(0, 1023), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 1023), 16'($urandom));
      step();
      guard++;
    end
    check({tag, "_busy_cycles_a"}, 32'(na), 32'(DEPTH_A));
    check({tag, "_busy_cycles_b"}, 32'(nb), 32'(DEPTH_B));
    set_in(1'b0, 0, 1'b0, 1'b0, 0, 16'h0);
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 1023);
      1:       return $urandom_range(760, 775);
      2:       return $urandom_range(0, 15);
      default: return $urandom_range(1016, 1023);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);
    check("rst_instr", 32'(bus_a.instr), 32'(NOP));
    check("rst_busy", 32'(bus_a.busy), 32'd1);
    wait_fill("init");

    // Post-fill fetch returns NOP
    set_in(1'b1, 100, 1'b0, 1'b0, 0, 16'h0); step();
    check("fill_instr", 32'(bus_a.instr), 32'h0000);
    check("fill_valid", 32'(bus_a.instr_valid), 32'd1);

    // Load two words, fetch back-to-back
    set_in(1'b0, 0, 1'b0, 1'b1, 0, 16'h2C06); step();
    set_in(1'b0, 0, 1'b0, 1'b1, 1, 16'h2406); step();
    set_in(1'b1, 0, 1'b0, 1'b0, 0, 16'h0); step();
    check("b2b_0", 32'(bus_a.instr), 32'h2C06);
    set_in(1'b1, 1, 1'b0, 1'b0, 0, 16'h0); step();
    check("b2b_1", 32'(bus_a.instr), 32'h2406);
    check("b2b_valid", 32'(bus_a.instr_valid), 32'd1);

    // Same-cycle load and fetch: write-first
    set_in(1'b1, 5, 1'b0, 1'b1, 5, 16'hA1B2); step();
    check("wf_instr", 32'(bus_a.instr), 32'hA1B2);
    set_in(1'b0, 0, 1'b0, 1'b0, 0, 16'h0); step();
    check("idle_valid", 32'(bus_a.instr_valid), 32'd0);
    check("idle_hold", 32'(bus_a.instr), 32'hA1B2);
    set_in(1'b1, 5, 1'b0, 1'b0, 0, 16'h0); step();
    check("wf_later", 32'(bus_a.instr), 32'hA1B2);

    // Stall holds outputs; dropped request is re-presented
    set_in(1'b0, 0, 1'b0, 1'b1, 3, 16'h6FFE); step();
    set_in(1'b0, 0, 1'b0, 1'b1, 4, 16'h1234); step();
    set_in(1'b1, 3, 1'b0, 1'b0, 0, 16'h0); step();
    check("stall_pre", 32'(bus_a.instr), 32'h6FFE);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 4, 1'b1, 1'b0, 0, 16'h0); step();
      check("stall_instr", 32'(bus_a.instr), 32'h6FFE);
      check("stall_valid", 32'(bus_a.instr_valid), 32'd1);
    end
    set_in(1'b1, 4, 1'b0, 1'b0, 0, 16'h0); step();
    check("stall_done", 32'(bus_a.instr), 32'h1234);

    // Range boundary on the 768-deep instance
    set_in(1'b1, 800, 1'b0, 1'b0, 0, 16'h0); step();
    check("oor_err_b", 32'(bus_b.addr_err), 32'd1);
    check("oor_instr_b", 32'(bus_b.instr), 32'(NOP));
    check("oor_valid_b", 32'(bus_b.instr_valid), 32'd1);
    check("oor_err_a", 32'(bus_a.addr_err), 32'd0);
    set_in(1'b1, 767, 1'b0, 1'b0, 0, 16'h0); step();
    check("edge767_err_b", 32'(bus_b.addr_err), 32'd0);
    set_in(1'b1, 768, 1'b0, 1'b0, 0, 16'h0); step();
    check("edge768_err_b", 32'(bus_b.addr_err), 32'd1);
    set_in(1'b0, 0, 1'b0, 1'b1, 800, 16'hBEEF); step();
    set_in(1'b1, 32, 1'b0, 1'b0, 0, 16'h0); step();
    check("nowrap_b", 32'(bus_b.instr), 32'h0000);
    set_in(1'b1, 800, 1'b0, 1'b0, 0, 16'h0); step();
    check("hi_load_a", 32'(bus_a.instr), 32'hBEEF);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      int fa;
      fa = pick_addr();
      set_in(1'($urandom_range(0, 3) != 0), fa, 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0) ? fa : pick_addr(), 16'($urandom));
      step();
    end
    set_in(1'b0, 0, 1'b0, 1'b0, 0, 16'h0);

    // Reset in the middle of the fill restarts it
    do_reset(2);
    for (int i = 0; i < 500; i++) begin
      set_in(1'b1, $urandom_range(0, 1023), 1'b0, 1'b0, 0, 16'h0);
      step();
      if (i == 499) check("mid_valid", 32'(bus_a.instr_valid), 32'd0);
    end
    do_reset(2);
    wait_fill("refill");
    set_in(1'b1, 0, 1'b0, 1'b0, 0, 16'h0); step();
    check("refill_instr", 32'(bus_a.instr), 32'h0000);
    check("refill_valid", 32'(bus_a.instr_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
